// File: rtl/pool_out_packer.sv
// Packs the pooled byte stream into 128-bit words, queues them in a small FIFO and
// writes them out with incrementing addresses. Optional stall counter: PACKER_STALL_CNT_EN.
module pool_out_packer #(
  parameter int ADDR_W     = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W:0]   frm_words_i,
  input  logic              flush_i,
  input  logic              vld_i,
  input  logic [7:0]        din_i,
  output logic              wr_vld_o,
  input  logic              wr_rdy_i,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [127:0]      wr_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              ovf_o,
  output logic [31:0]       stall_cnt_o
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state_q;
  logic [3:0]          idx_q;
  logic [127:0]        acc_q;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W:0]     frm_q;
  logic [ADDR_W:0]     pushed_q;
  logic [ADDR_W:0]     wr_cnt_q;
  logic [127:0]        mem_q [FIFO_DEPTH];
  logic [PW-1:0]       rd_ptr_q;
  logic [PW-1:0]       wr_ptr_q;
  logic [PW:0]         cnt_q;
  logic                ovf_q;

  logic                accept;
  logic                byte_v;
  logic                flush_v;
  logic                push;
  logic                push_ok;
  logic                pop;
  logic                empty;
  logic                full;
  logic                frame_end;
  logic [127:0]        acc_d;
  logic [ADDR_W:0]     pushed_d;

  assign accept  = (state_q == IDLE) && start_i;
  assign byte_v  = (state_q == RUN) && vld_i;
  assign flush_v = (state_q == RUN) && flush_i;
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (PW+1)'(FIFO_DEPTH));
  assign pop     = !empty && wr_rdy_i;

  // Unfilled upper bytes stay zero because acc_q is cleared after every push.
  always_comb begin
    acc_d = acc_q;
    if (byte_v) acc_d[{idx_q, 3'b000} +: 8] = din_i;
  end

  // A flush whose accompanying byte completes the word yields only that one word.
  assign push      = (byte_v && (idx_q == 4'd15)) ||
                     (flush_v && ((idx_q != 4'd0) || byte_v));
  assign push_ok   = push && (!full || pop);
  assign pushed_d  = push ? pushed_q + 1'b1 : pushed_q;
  assign frame_end = push && (frm_q != '0) && (pushed_d == frm_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      acc_q    <= '0;
      base_q   <= '0;
      frm_q    <= '0;
      pushed_q <= '0;
      wr_cnt_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            base_q   <= base_addr_i;
            frm_q    <= frm_words_i;
            idx_q    <= '0;
            acc_q    <= '0;
            pushed_q <= '0;
            wr_cnt_q <= '0;
            ovf_q    <= 1'b0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          if (push) begin
            idx_q    <= '0;
            acc_q    <= '0;
            pushed_q <= pushed_d;
            if (!push_ok) ovf_q <= 1'b1;
          end else if (byte_v) begin
            idx_q <= idx_q + 4'd1;
            acc_q <= acc_d;
          end
          if (flush_i || frame_end) state_q <= DRAIN;
        end
        DRAIN: begin
          if (empty) state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase

      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        wr_cnt_q <= wr_cnt_q + 1'b1;
      end
      cnt_q <= cnt_q + {{PW{1'b0}}, push_ok} - {{PW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= acc_d;
  end

  assign wr_vld_o  = !empty;
  assign wr_data_o = empty ? '0 : mem_q[rd_ptr_q];
  assign wr_addr_o = base_q + wr_cnt_q[ADDR_W-1:0];
  assign busy_o    = (state_q != IDLE);
  assign done_o    = (state_q == DONE);
  assign ovf_o     = ovf_q;

`ifdef PACKER_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (accept) begin
      stall_q <= '0;
    end else if (!empty && !wr_rdy_i && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pool_out_packer.sv
// Directed bench for pool_out_packer; honours PACKER_STALL_CNT_EN for the stall-count step.
module tb_pool_out_packer;

  localparam int ADDR_W = 12;

  logic              clk;
  logic              rst;
  logic              start_i;
  logic [ADDR_W-1:0] base_addr_i;
  logic [ADDR_W:0]   frm_words_i;
  logic              flush_i;
  logic              vld_i;
  logic [7:0]        din_i;
  logic              wr_vld_o;
  logic              wr_rdy_i;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [127:0]      wr_data_o;
  logic              busy_o;
  logic              done_o;
  logic              ovf_o;
  logic [31:0]       stall_cnt_o;

  pool_out_packer #(.ADDR_W(ADDR_W), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .frm_words_i (frm_words_i),
    .flush_i     (flush_i),
    .vld_i       (vld_i),
    .din_i       (din_i),
    .wr_vld_o    (wr_vld_o),
    .wr_rdy_i    (wr_rdy_i),
    .wr_addr_o   (wr_addr_o),
    .wr_data_o   (wr_data_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .ovf_o       (ovf_o),
    .stall_cnt_o (stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  logic [ADDR_W-1:0] wa_q [$];
  logic [127:0]      wd_q [$];

  // Transfers are recorded mid-cycle; inputs change only just after the rising edge.
  always @(negedge clk) begin
    if (wr_vld_o && wr_rdy_i) begin
      wa_q.push_back(wr_addr_o);
      wd_q.push_back(wr_data_o);
    end
    if (done_o) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_frame(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] frm);
    base_addr_i = base;
    frm_words_i = frm;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (!busy_o) break;
      tick();
    end
    chk("idle_reached", {127'd0, busy_o}, 128'd0);
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    done_cnt = 0;
  endtask

  logic [127:0] exp_w;

  initial begin
    rst = 1'b1; start_i = 1'b0; base_addr_i = '0; frm_words_i = '0;
    flush_i = 1'b0; vld_i = 1'b0; din_i = '0; wr_rdy_i = 1'b0;
    repeat (2) tick();
    chk("rst_wr_vld", {127'd0, wr_vld_o}, 128'd0);
    chk("rst_busy",   {127'd0, busy_o},   128'd0);
    chk("rst_done",   {127'd0, done_o},   128'd0);
    chk("rst_ovf",    {127'd0, ovf_o},    128'd0);
    chk("rst_addr",   {116'd0, wr_addr_o}, 128'd0);
    chk("rst_data",   wr_data_o, 128'd0);
    chk("rst_stall",  {96'd0, stall_cnt_o}, 128'd0);
    rst = 1'b0;
    tick();

    // Full frame of two words
    clear_log();
    wr_rdy_i = 1'b1;
    start_frame(12'h010, 13'd2);
    for (int i = 0; i < 32; i++) begin
      vld_i = 1'b1; din_i = 8'(i);
      tick();
    end
    vld_i = 1'b0;
    wait_idle(40);
    chk("full_nwr",   128'(wa_q.size()), 128'd2);
    chk("full_addr0", {116'd0, wa_q[0]}, 128'h010);
    chk("full_data0", wd_q[0], 128'h0F0E0D0C0B0A09080706050403020100);
    chk("full_addr1", {116'd0, wa_q[1]}, 128'h011);
    chk("full_data1", wd_q[1], 128'h1F1E1D1C1B1A19181716151413121110);
    chk("full_done",  128'(done_cnt), 128'd1);
    chk("full_ovf",   {127'd0, ovf_o}, 128'd0);

    // Partial word flushed with zero padding
    clear_log();
    start_frame(12'h020, 13'd0);
    for (int i = 0; i < 5; i++) begin
      vld_i = 1'b1; din_i = 8'hA1 + 8'(i);
      tick();
    end
    vld_i = 1'b0;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    wait_idle(40);
    chk("part_nwr",  128'(wa_q.size()), 128'd1);
    chk("part_addr", {116'd0, wa_q[0]}, 128'h020);
    chk("part_data", wd_q[0], 128'h0000000000000000000000A5A4A3A2A1);
    chk("part_done", 128'(done_cnt), 128'd1);

    // Overflow: five words into a four-deep FIFO with the port blocked
    clear_log();
    wr_rdy_i = 1'b0;
    start_frame(12'h100, 13'd6);
    for (int i = 0; i < 80; i++) begin
      vld_i = 1'b1; din_i = 8'(i);
      tick();
    end
    vld_i = 1'b0;
    chk("ovf_set",    {127'd0, ovf_o}, 128'd1);
    chk("ovf_vld",    {127'd0, wr_vld_o}, 128'd1);
    chk("ovf_hold_a", {116'd0, wr_addr_o}, 128'h100);
    chk("ovf_hold_d", wr_data_o, 128'h0F0E0D0C0B0A09080706050403020100);
    chk("ovf_nowr",   128'(wa_q.size()), 128'd0);
    wr_rdy_i = 1'b1;
    repeat (8) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    wait_idle(40);
    chk("ovf_nwr", 128'(wa_q.size()), 128'd4);
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 16; j++) exp_w[8*j +: 8] = 8'(16*k + j);
      chk("ovf_addr", {116'd0, wa_q[k]}, 128'(12'h100 + k));
      chk("ovf_data", wd_q[k], exp_w);
    end
    chk("ovf_sticky", {127'd0, ovf_o}, 128'd1);
    chk("ovf_done",   128'(done_cnt), 128'd1);

    // Reset in the middle of a frame
    clear_log();
    start_frame(12'h040, 13'd0);
    for (int i = 0; i < 7; i++) begin
      vld_i = 1'b1; din_i = 8'h70 + 8'(i);
      tick();
    end
    vld_i = 1'b0;
    rst = 1'b1;
    #1;
    chk("mrst_vld",  {127'd0, wr_vld_o}, 128'd0);
    chk("mrst_busy", {127'd0, busy_o}, 128'd0);
    tick();
    rst = 1'b0;
    tick();
    start_frame(12'h050, 13'd0);
    vld_i = 1'b1; din_i = 8'h5A;
    tick();
    vld_i = 1'b0;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    wait_idle(40);
    chk("mrst_nwr",  128'(wa_q.size()), 128'd1);
    chk("mrst_addr", {116'd0, wa_q[0]}, 128'h050);
    chk("mrst_data", wd_q[0], 128'h5A);

    // Bytes while idle are ignored
    clear_log();
    for (int i = 0; i < 16; i++) begin
      vld_i = 1'b1; din_i = 8'(i);
      tick();
    end
    vld_i = 1'b0;
    repeat (3) tick();
    chk("idle_nowr", 128'(wa_q.size()), 128'd0);
    chk("idle_busy", {127'd0, busy_o}, 128'd0);

    // Start while busy ignored; flush together with the 32nd byte
    clear_log();
    start_frame(12'h060, 13'd0);
    for (int i = 0; i < 32; i++) begin
      vld_i = 1'b1; din_i = 8'h40 + 8'(i);
      start_i = (i == 8);
      base_addr_i = (i == 8) ? 12'h300 : 12'h060;
      frm_words_i = (i == 8) ? 13'd1 : 13'd0;
      flush_i = (i == 31);
      tick();
    end
    vld_i = 1'b0; start_i = 1'b0; flush_i = 1'b0;
    wait_idle(40);
    chk("sb_nwr",   128'(wa_q.size()), 128'd2);
    chk("sb_addr0", {116'd0, wa_q[0]}, 128'h060);
    chk("sb_addr1", {116'd0, wa_q[1]}, 128'h061);
    chk("sb_data1", wd_q[1], 128'h5F5E5D5C5B5A59585756555453525150);
    chk("sb_done",  128'(done_cnt), 128'd1);

    // Stall counter: one word held for nine cycles
    clear_log();
    wr_rdy_i = 1'b0;
    start_frame(12'h070, 13'd1);
    for (int i = 0; i < 16; i++) begin
      vld_i = 1'b1; din_i = 8'(i);
      tick();
    end
    vld_i = 1'b0;
    repeat (9) tick();
`ifdef PACKER_STALL_CNT_EN
    chk("stall_9", {96'd0, stall_cnt_o}, 128'd9);
`else
    chk("stall_off", {96'd0, stall_cnt_o}, 128'd0);
`endif
    wr_rdy_i = 1'b1;
    wait_idle(40);
    chk("stall_nwr",  128'(wa_q.size()), 128'd1);
    chk("stall_addr", {116'd0, wa_q[0]}, 128'h070);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
